// File: rtl/miner_controller.sv
// miner_controller: nonce-search sequencer between MinerRegisters and the hash core.
// Watches the control word, streams nonces to the core over valid/ready,
// records hit/exhaustion status and clears the active control bit when done.
module miner_controller #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] controlIn,
  input  logic [DW-1:0] startNonce,
  output logic          controlWrite,
  output logic [DW-1:0] controlOut,
  output logic          hashStart,
  input  logic          hashReady,
  output logic [DW-1:0] hashNonce,
  input  logic          hashDone,
  input  logic          hashHit,
  output logic          busy,
  output logic          foundValid,
  output logic [DW-1:0] foundNonce,
  output logic          exhausted,
  output logic [DW-1:0] hashCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t        state, stateNext;
  logic          modeMine;   // latched at start: 1 = mine, 0 = single
  logic          abortFlag;  // software dropped the mine bit mid-search
  logic [DW-1:0] nonce;
  logic [DW-1:0] clrMask;    // control bit owned by the running action

  logic startReq, abortNow, abortEff, nonceLast;

  // Decode start/abort conditions and compute the next FSM state.
  always_comb begin
    startReq  = controlIn[0] | controlIn[1];
    abortNow  = modeMine & ~controlIn[0] & ((state == ISSUE) | (state == WAIT));
    // Include the live sample so an abort seen in the hashDone cycle counts.
    abortEff  = abortFlag | abortNow;
    nonceLast = &nonce;
    stateNext = state;
    case (state)
      IDLE:  if (startReq) stateNext = ISSUE;
      ISSUE: if (hashStart && hashReady) stateNext = WAIT;
      WAIT: begin
        if (hashDone) begin
          if (hashHit || !modeMine) stateNext = CLEAR;
          else if (abortEff)        stateNext = IDLE;
          else if (nonceLast)       stateNext = CLEAR;
          else                      stateNext = ISSUE;
        end
      end
      CLEAR:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register plus the handshake/status flags derived from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      hashStart    <= 1'b0;
      busy         <= 1'b0;
      controlWrite <= 1'b0;
    end else begin
      state        <= stateNext;
      hashStart    <= (stateNext == ISSUE);
      busy         <= (stateNext != IDLE);
      controlWrite <= (stateNext == CLEAR);
    end
  end

  // Search datapath: nonce, mode, abort, result and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nonce      <= '0;
      modeMine   <= 1'b0;
      abortFlag  <= 1'b0;
      clrMask    <= '0;
      foundValid <= 1'b0;
      foundNonce <= '0;
      exhausted  <= 1'b0;
      hashCount  <= '0;
    end else begin
      if (state == IDLE && startReq) begin
        nonce      <= startNonce;
        modeMine   <= controlIn[0];
        abortFlag  <= 1'b0;
        // Bit 0 wins when both are set, so the mask follows bit 0.
        clrMask    <= {{(DW-2){1'b0}}, ~controlIn[0], controlIn[0]};
        foundValid <= 1'b0;
        exhausted  <= 1'b0;
        hashCount  <= '0;
      end
      if (abortNow) abortFlag <= 1'b1;
      if (state == WAIT && hashDone) begin
        if (~&hashCount) hashCount <= hashCount + DW'(1);
        if (hashHit) begin
          foundNonce <= nonce;
          foundValid <= 1'b1;
        end else if (modeMine && !abortEff) begin
          if (nonceLast) exhausted <= 1'b1;
          else           nonce     <= nonce + DW'(1);
        end
      end
    end
  end

  assign hashNonce = nonce;

  // The clear value passes through the other control bits as they read in the
  // write cycle itself, so a concurrent software change to them is kept.
  assign controlOut = controlWrite ? (controlIn & ~clrMask) : '0;

endmodule

// File: tb/tb_miner_controller.sv
// Scoreboard bench for miner_controller: a small hash-core model and a
// control-register model surround the DUT; expected requests and control
// writes are queued by the stimulus and checked by monitor processes.
module tb_miner_controller;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] controlIn, startNonce, controlOut, hashNonce, foundNonce, hashCount;
  logic controlWrite, hashStart, hashReady, hashDone, hashHit, busy, foundValid, exhausted;

  logic [DW-1:0] controlReg = '0;
  logic          swWe = 1'b0;
  logic [DW-1:0] swData = '0;
  assign controlIn = controlReg;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] expNonceQ[$];
  logic [DW-1:0] expCtlQ[$];

  int            coreLat = 4;
  logic          hitEn = 1'b0;
  logic [DW-1:0] hitNonce = '0;
  int            stallCnt = 0;
  logic          coreBusy = 1'b0;
  int            lat = 0;
  logic [DW-1:0] curNonce = '0;

  miner_controller #(.DW(DW)) dut (
    .clk(clk), .rstn(rstn), .controlIn(controlIn), .startNonce(startNonce),
    .controlWrite(controlWrite), .controlOut(controlOut),
    .hashStart(hashStart), .hashReady(hashReady), .hashNonce(hashNonce),
    .hashDone(hashDone), .hashHit(hashHit), .busy(busy),
    .foundValid(foundValid), .foundNonce(foundNonce), .exhausted(exhausted),
    .hashCount(hashCount)
  );

  // Register block: the controller's clear write has priority over software.
  always @(posedge clk) begin
    if (controlWrite) controlReg <= controlOut;
    else if (swWe)    controlReg <= swData;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // Hash core model plus request monitor (ready and handshake decided together).
  initial begin
    hashReady = 1'b0;
    hashDone  = 1'b0;
    hashHit   = 1'b0;
    forever begin
      @(negedge clk);
      hashDone = 1'b0;
      hashHit  = 1'b0;
      if (coreBusy) begin
        if (lat == 0) begin
          hashDone = 1'b1;
          hashHit  = hitEn && (curNonce == hitNonce);
          coreBusy = 1'b0;
        end else lat--;
      end
      if (hashStart && stallCnt > 0) begin
        hashReady = 1'b0;
        stallCnt--;
      end else hashReady = !coreBusy;
      if (hashStart) begin
        if (hashReady) begin
          if (expNonceQ.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL reqUnexpected: got request nonce 0x%0h, expected none", hashNonce);
          end else chk("reqNonce", hashNonce, expNonceQ.pop_front());
          coreBusy = 1'b1;
          lat      = coreLat;
          curNonce = hashNonce;
        end else if (expNonceQ.size() != 0) begin
          chk("stallNonce", hashNonce, expNonceQ[0]);
        end
      end
    end
  end

  // Control-write monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (controlWrite) begin
        if (expCtlQ.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL ctlUnexpected: got write 0x%0h, expected none", controlOut);
        end else chk("ctlOut", controlOut, expCtlQ.pop_front());
      end
    end
  end

  task automatic swWrite(input logic [DW-1:0] v);
    @(negedge clk);
    swWe   = 1'b1;
    swData = v;
    @(negedge clk);
    swWe   = 1'b0;
  endtask

  task automatic waitAction(input string name);
    int i;
    for (i = 0; i < 50 && !busy; i++) @(negedge clk);
    if (!busy) timeoutFail({name, "Start"});
    for (i = 0; i < 1000 && busy; i++) @(negedge clk);
    if (busy) timeoutFail({name, "End"});
  endtask

  initial begin
    startNonce = '0;
    #2 rstn = 1'b0;
    #20;
    chk("rstHashStart", {31'd0, hashStart}, 0);
    chk("rstBusy", {31'd0, busy}, 0);
    chk("rstCtlWrite", {31'd0, controlWrite}, 0);
    chk("rstHashCount", hashCount, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Single hash with hit
    startNonce = 32'h1234; coreLat = 4; hitEn = 1'b1; hitNonce = 32'h1234;
    expNonceQ.push_back(32'h1234); expCtlQ.push_back(32'h0);
    swWrite(32'h2);
    waitAction("single");
    chk("singleFoundValid", {31'd0, foundValid}, 1);
    chk("singleFoundNonce", foundNonce, 32'h1234);
    chk("singleCount", hashCount, 1);
    chk("singleExhausted", {31'd0, exhausted}, 0);
    chk("singleCtlReg", controlReg, 0);

    // Mining hit at 13
    startNonce = 32'd10; hitNonce = 32'd13; coreLat = 3;
    for (int n = 10; n <= 13; n++) expNonceQ.push_back(DW'(n));
    expCtlQ.push_back(32'h0);
    swWrite(32'h1);
    waitAction("mine");
    chk("mineFoundNonce", foundNonce, 32'd13);
    chk("mineFoundValid", {31'd0, foundValid}, 1);
    chk("mineCount", hashCount, 4);
    chk("mineCtlReg", controlReg, 0);

    // Wrap without hit
    startNonce = 32'hFFFF_FFFE; hitEn = 1'b0;
    expNonceQ.push_back(32'hFFFF_FFFE); expNonceQ.push_back(32'hFFFF_FFFF);
    expCtlQ.push_back(32'h0);
    swWrite(32'h1);
    waitAction("wrap");
    chk("wrapExhausted", {31'd0, exhausted}, 1);
    chk("wrapFoundValid", {31'd0, foundValid}, 0);
    chk("wrapCount", hashCount, 2);
    chk("wrapCtlReg", controlReg, 0);

    // Abort while the hash for nonce 3 is in flight
    startNonce = 32'd0; coreLat = 8;
    for (int n = 0; n <= 3; n++) expNonceQ.push_back(DW'(n));
    swWrite(32'h1);
    begin
      int i;
      for (i = 0; i < 300 && !(busy && !hashStart && hashNonce == 32'd3); i++) @(negedge clk);
      if (!(busy && !hashStart && hashNonce == 32'd3)) timeoutFail("abortReach3");
    end
    swWrite(32'h0);
    waitAction("abort");
    repeat (10) @(negedge clk);
    chk("abortCount", hashCount, 4);
    chk("abortFoundValid", {31'd0, foundValid}, 0);
    chk("abortExhausted", {31'd0, exhausted}, 0);
    chk("abortHashStart", {31'd0, hashStart}, 0);
    chk("abortBusy", {31'd0, busy}, 0);

    // Backpressure with both mode bits: mine first, then single restarts on bit 1
    startNonce = 32'h55; hitEn = 1'b1; hitNonce = 32'h55; coreLat = 2; stallCnt = 4;
    expNonceQ.push_back(32'h55); expNonceQ.push_back(32'h55);
    expCtlQ.push_back(32'h2); expCtlQ.push_back(32'h0);
    swWrite(32'h3);
    repeat (60) @(negedge clk);
    chk("prioCtlReg", controlReg, 0);
    chk("prioBusy", {31'd0, busy}, 0);
    chk("prioFoundNonce", foundNonce, 32'h55);
    chk("prioCount", hashCount, 1);
    chk("prioStallUsed", DW'(stallCnt), 0);

    // Reset in the middle of WAIT
    startNonce = 32'h100; hitEn = 1'b0; coreLat = 20;
    expNonceQ.push_back(32'h100);
    swWrite(32'h1);
    begin
      int i;
      for (i = 0; i < 100 && !(busy && !hashStart); i++) @(negedge clk);
      if (!(busy && !hashStart)) timeoutFail("rstReachWait");
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midRstHashStart", {31'd0, hashStart}, 0);
    chk("midRstHashNonce", hashNonce, 0);
    chk("midRstCtlWrite", {31'd0, controlWrite}, 0);
    chk("midRstCtlOut", controlOut, 0);
    chk("midRstBusy", {31'd0, busy}, 0);
    chk("midRstFoundValid", {31'd0, foundValid}, 0);
    chk("midRstFoundNonce", foundNonce, 0);
    chk("midRstExhausted", {31'd0, exhausted}, 0);
    chk("midRstCount", hashCount, 0);
    chk("midRstCtlRegKept", controlReg, 32'h1);
    swWrite(32'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    chk("postRstBusy", {31'd0, busy}, 0);
    chk("postRstHashStart", {31'd0, hashStart}, 0);
    chk("postRstCount", hashCount, 0);

    chk("nonceQEmpty", DW'(expNonceQ.size()), 0);
    chk("ctlQEmpty", DW'(expCtlQ.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
